// File: rtl/alu_issue_seq.sv
// Issue sequencer for a combinational 32-bit MIPS ALU (nor takes two passes).
// Optional signed-overflow trap on add/addi: define ALU_OVF_TRAP_EN.
module alu_issue_seq #(
    parameter int DATA_W  = 32,
    parameter bit SLT_FIX = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_rs_val,
    input  logic [DATA_W-1:0] in_rt_val,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_c,
    input  logic              alu_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic              out_illegal,
    output logic              out_exc
);

    generate
        if (DATA_W != 32) begin : g_bad_width
            $error("alu_issue_seq: only DATA_W=32 is supported");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        PASS1,
        PASS2,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        C_ADD,
        C_ADDU,
        C_SUB,
        C_LOGIC,
        C_NOR,
        C_SLT,
        C_ILL
    } cls_t;

    localparam logic [3:0] OP_SLT = 4'b0000;
    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_NOT = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_ADD = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_NOP = 4'b1001;

    state_t            state_q;
    cls_t              cls_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [3:0]        alu_op_q;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;
    logic              illegal_q;

    logic [5:0]        opc;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [3:0]        dec_op;
    logic [DATA_W-1:0] dec_b;
    cls_t              dec_cls;

    logic [DATA_W-1:0] cap_result;
    logic              cap_illegal;
    logic              cap_exc;

    logic unused_instr;
    assign unused_instr = ^in_instr[25:16];

    assign opc   = in_instr[31:26];
    assign funct = in_instr[5:0];
    assign imm   = in_instr[15:0];

    always_comb begin
        dec_op  = OP_NOP;
        dec_b   = in_rt_val;
        dec_cls = C_ILL;
        case (opc)
            6'h00: begin
                case (funct)
                    6'h20: begin dec_op = OP_ADD; dec_cls = C_ADD;   end
                    6'h21: begin dec_op = OP_ADD; dec_cls = C_ADDU;  end
                    6'h22,
                    6'h23: begin dec_op = OP_SUB; dec_cls = C_SUB;   end
                    6'h24: begin dec_op = OP_AND; dec_cls = C_LOGIC; end
                    6'h25: begin dec_op = OP_OR;  dec_cls = C_LOGIC; end
                    6'h26: begin dec_op = OP_XOR; dec_cls = C_LOGIC; end
                    6'h27: begin dec_op = OP_OR;  dec_cls = C_NOR;   end
                    6'h2A: begin dec_op = OP_SLT; dec_cls = C_SLT;   end
                    default: ;
                endcase
            end
            6'h08: begin
                dec_op  = OP_ADD;
                dec_b   = {{16{imm[15]}}, imm};
                dec_cls = C_ADD;
            end
            6'h0C: begin
                dec_op  = OP_AND;
                dec_b   = {16'h0000, imm};
                dec_cls = C_LOGIC;
            end
            6'h0D: begin
                dec_op  = OP_OR;
                dec_b   = {16'h0000, imm};
                dec_cls = C_LOGIC;
            end
            6'h0E: begin
                dec_op  = OP_XOR;
                dec_b   = {16'h0000, imm};
                dec_cls = C_LOGIC;
            end
            6'h04: begin
                dec_op  = OP_SUB;
                dec_cls = C_SUB;
            end
            default: ;
        endcase
    end

    // The ALU reports signed compare inverted; bit 0 is flipped for slt.
    always_comb begin
        cap_result  = alu_c;
        cap_illegal = 1'b0;
        cap_exc     = 1'b0;
        if (cls_q == C_SLT && SLT_FIX) begin
            cap_result = {{(DATA_W-1){1'b0}}, ~alu_c[0]};
        end
        if (cls_q == C_ILL) begin
            cap_result  = '0;
            cap_illegal = 1'b1;
        end
`ifdef ALU_OVF_TRAP_EN
        if (cls_q == C_ADD &&
            alu_a_q[DATA_W-1] == alu_b_q[DATA_W-1] &&
            alu_c[DATA_W-1] != alu_a_q[DATA_W-1]) begin
            cap_result = '0;
            cap_exc    = 1'b1;
        end
`endif
    end

`ifdef ALU_OVF_TRAP_EN
    logic exc_q;
    assign out_exc = exc_q;
`else
    logic unused_exc;
    assign unused_exc = cap_exc;
    assign out_exc    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cls_q       <= C_ILL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= OP_NOP;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
`ifdef ALU_OVF_TRAP_EN
            exc_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        alu_a_q    <= in_rs_val;
                        alu_b_q    <= dec_b;
                        alu_op_q   <= dec_op;
                        cls_q      <= dec_cls;
                        in_ready_q <= 1'b0;
                        state_q    <= PASS1;
                    end
                end
                PASS1: begin
                    if (cls_q == C_NOR) begin
                        alu_a_q  <= alu_c;
                        alu_op_q <= OP_NOT;
                        state_q  <= PASS2;
                    end else begin
                        result_q  <= cap_result;
                        zero_q    <= alu_zero;
                        illegal_q <= cap_illegal;
`ifdef ALU_OVF_TRAP_EN
                        exc_q     <= cap_exc;
`endif
                        state_q   <= DONE;
                    end
                end
                PASS2: begin
                    result_q  <= cap_result;
                    zero_q    <= alu_zero;
                    illegal_q <= cap_illegal;
`ifdef ALU_OVF_TRAP_EN
                    exc_q     <= cap_exc;
`endif
                    state_q   <= DONE;
                end
                DONE: begin
                    // Valid is raised one cycle after capture.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        illegal_q   <= 1'b0;
`ifdef ALU_OVF_TRAP_EN
                        exc_q       <= 1'b0;
`endif
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign out_result  = result_q;
    assign out_zero    = zero_q;
    assign out_illegal = illegal_q;

endmodule
